// File: rtl/sid_envelope.sv
// ADSR envelope generator for the SID voice: gate-driven ATTACK/DECAY/SUSTAIN/RELEASE level sequencer.
// Optional piecewise-exponential DECAY/RELEASE tail enabled by defining SID_ENV_EXP_DECAY_EN.
module sid_envelope #(
  parameter int unsigned PRESCALE_BASE = 1,
  parameter int unsigned CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sid_attack,
  input  logic [7:0] sid_sustain,
  input  logic [7:0] sid_waveform,
  output logic [7:0] env_out,
  output logic [2:0] env_state,
  output logic       env_active
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  env_state_e       state_q, state_d;
  logic [7:0]       env_q, env_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_q;
  logic             active_q, active_d;

  logic             rise_s, fall_s, tick_s;
  logic [3:0]       rate_s;
  logic [2:0]       k_s;
  logic [4:0]       shift_s;
  logic [CNT_W-1:0] period_s;
  logic [7:0]       sus_lvl_s;
  logic             wave_unused_s;

`ifdef SID_ENV_EXP_DECAY_EN
  // Extra period shift that bends the DECAY/RELEASE slope as the level falls.
  function automatic logic [2:0] exp_k(input logic [7:0] lvl);
    logic [2:0] k;
    if (lvl >= 8'h5D) begin
      k = 3'd0;
    end else if (lvl >= 8'h36) begin
      k = 3'd1;
    end else if (lvl >= 8'h1A) begin
      k = 3'd2;
    end else if (lvl >= 8'h0E) begin
      k = 3'd3;
    end else if (lvl >= 8'h06) begin
      k = 3'd4;
    end else begin
      k = 3'd5;
    end
    return k;
  endfunction
`endif

  assign rise_s        = sid_waveform[0] & ~gate_q;
  assign fall_s        = ~sid_waveform[0] & gate_q;
  assign sus_lvl_s     = {sid_sustain[3:0], sid_sustain[3:0]};
  assign wave_unused_s = ^sid_waveform[7:1];

  // Step period selection and tick generation; rate fields are used live.
  always_comb begin
    rate_s = 4'd0;
    k_s    = 3'd0;
    case (state_q)
      ST_ATTACK:  rate_s = sid_attack[3:0];
      ST_DECAY:   rate_s = sid_attack[7:4];
      ST_RELEASE: rate_s = sid_sustain[7:4];
      default:    rate_s = 4'd0;
    endcase
`ifdef SID_ENV_EXP_DECAY_EN
    if ((state_q == ST_DECAY) || (state_q == ST_RELEASE)) begin
      k_s = exp_k(env_q);
    end else begin
      k_s = 3'd0;
    end
`endif
    shift_s  = {1'b0, rate_s} + {2'b00, k_s};
    period_s = CNT_W'(PRESCALE_BASE) << shift_s;
    tick_s   = (cnt_q >= (period_s - CNT_W'(1)));
  end

  // Next-state, next-level and rate counter logic; gate edges outrank ticks.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise_s) begin
      state_d = ST_ATTACK;
    end else if (fall_s) begin
      state_d = ST_RELEASE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          env_d = 8'h00;
        end
        ST_ATTACK: begin
          if (env_q == 8'hFF) begin
            state_d = ST_DECAY;
          end else if (tick_s) begin
            env_d = env_q + 8'd1;
            if (env_q == 8'hFE) begin
              state_d = ST_DECAY;
            end else begin
              state_d = ST_ATTACK;
            end
          end else begin
            state_d = ST_ATTACK;
          end
        end
        ST_DECAY: begin
          if (env_q <= sus_lvl_s) begin
            state_d = ST_SUSTAIN;
          end else if (tick_s) begin
            env_d = env_q - 8'd1;
          end else begin
            env_d = env_q;
          end
        end
        ST_SUSTAIN: begin
          state_d = ST_SUSTAIN;
        end
        ST_RELEASE: begin
          if (env_q == 8'h00) begin
            state_d = ST_IDLE;
          end else if (tick_s) begin
            env_d = env_q - 8'd1;
          end else begin
            env_d = env_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          env_d   = 8'h00;
        end
      endcase
    end

    if (rise_s || fall_s || (state_d != state_q) || tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    active_d = (state_d != ST_IDLE);
  end

  // State registers; gate history keeps tracking during reset so a held gate is not a rise.
  always_ff @(posedge clk) begin
    gate_q <= sid_waveform[0];
    if (rst) begin
      state_q  <= ST_IDLE;
      env_q    <= 8'h00;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign env_out    = env_q;
  assign env_state  = state_q;
  assign env_active = active_q;

endmodule
